// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: runs a 1-bit add/sub/and/or slice across a WIDTH-bit
// operand pair, LSB first, with valid/ready handshakes and registered Z/C/V flags.
module alu_serial_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;
    logic             start_ready_q, start_ready_d;
    logic             busy_q, busy_d;
    logic             done_valid_q, done_valid_d;

    logic             beff_s;
    logic             sum_s;
    logic             cout_s;
    logic             bit_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] final_res_s;

    // The operand registers shift right, so bit i of each operand sits at index 0.
    assign beff_s      = op_q[0] ? ~b_q[0] : b_q[0];
    assign sum_s       = a_q[0] ^ beff_s ^ carry_q;
    assign cout_s      = maj3(a_q[0], beff_s, carry_q);
    assign last_bit_s  = (cnt_q == CW'(WIDTH - 1));
    assign final_res_s = {bit_s, res_sh_q[WIDTH-1:1]};

    // Slice output select: logic ops use the raw b bit, not the inverted one.
    always_comb begin
        bit_s = 1'b0;
        case (op_q)
            2'b00:   bit_s = sum_s;
            2'b01:   bit_s = sum_s;
            2'b10:   bit_s = a_q[0] & b_q[0];
            2'b11:   bit_s = a_q[0] | b_q[0];
            default: bit_s = 1'b0;
        endcase
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = alu_control;
                    carry_d  = alu_control[0];
                    cnt_d    = '0;
                    res_sh_d = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                carry_d  = cout_s;
                res_sh_d = final_res_s;
                if (last_bit_s) begin
                    // carry_q here is the carry into the MSB; cout_s is the carry out.
                    cnt_d    = '0;
                    result_d = final_res_s;
                    flag_z_d = ~|final_res_s;
                    flag_c_d = ~op_q[1] & cout_s;
                    flag_v_d = ~op_q[1] & (carry_q ^ cout_s);
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        start_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        done_valid_d  = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= 2'b00;
            carry_q       <= 1'b0;
            cnt_q         <= '0;
            res_sh_q      <= '0;
            result_q      <= '0;
            flag_z_q      <= 1'b0;
            flag_c_q      <= 1'b0;
            flag_v_q      <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            carry_q       <= carry_d;
            cnt_q         <= cnt_d;
            res_sh_q      <= res_sh_d;
            result_q      <= result_d;
            flag_z_q      <= flag_z_d;
            flag_c_q      <= flag_c_d;
            flag_v_q      <= flag_v_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            done_valid_q  <= done_valid_d;
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign done_valid  = done_valid_q;
    assign result      = result_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
    assign flag_v      = flag_v_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed self-checking bench for alu_serial_sequencer with WIDTH=32.
module tb_alu_serial_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  alu_control;
    logic [31:0] result;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic        busy;
    logic        done_valid;
    logic        done_ready;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_accept = 0;
    int and_accept = 0;

    alu_serial_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .result      (result),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done
    // (and, when release is set, one cycle later with the DUT back in IDLE).
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [1:0] ctl, input logic [31:0] exp_r,
                          input logic ez, input logic ec, input logic ev,
                          input logic release_done);
        int cycles;
        check_eq({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        a           = av;
        b           = bv;
        alu_control = ctl;
        start_valid = 1'b1;
        done_ready  = release_done;
        @(negedge clk);
        last_accept = cyc;
        start_valid = 1'b0;
        a           = 32'h0;
        b           = 32'h0;
        alu_control = 2'b00;
        cycles      = 0;
        while (!done_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, "_latency"}, 32'(cycles), 32'd32);
        check_eq({tag, "_result"}, result, exp_r);
        check_eq({tag, "_z"}, 32'(flag_z), 32'(ez));
        check_eq({tag, "_c"}, 32'(flag_c), 32'(ec));
        check_eq({tag, "_v"}, 32'(flag_v), 32'(ev));
        if (release_done) begin
            @(negedge clk);
            check_eq({tag, "_done_pulse"}, 32'(done_valid), 32'd0);
            check_eq({tag, "_ready_after"}, 32'(start_ready), 32'd1);
            check_eq({tag, "_result_kept"}, result, exp_r);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        a           = 32'h0;
        b           = 32'h0;
        alu_control = 2'b00;
        done_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_start_ready", 32'(start_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done_valid", 32'(done_valid), 32'd0);
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd0);

        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("add_min", 32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        run_op("sub_eq",  32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op("sub_brw", 32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("and_op",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b1);
        and_accept = last_accept;
        run_op("or_op",   32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b11, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("op_spacing", 32'(last_accept - and_accept), 32'd34);

        // Backpressure: result held while done_ready is low; a command pulse is ignored.
        run_op("bp", 32'hFFFF_FFFF, 32'h8000_0000, 2'b00, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a           = 32'h0000_0003;
                b           = 32'h0000_0004;
                start_valid = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
            @(negedge clk);
            check_eq("bp_hold_result", result, 32'h7FFF_FFFF);
            check_eq("bp_hold_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd3);
            check_eq("bp_hold_valid", 32'(done_valid), 32'd1);
            check_eq("bp_hold_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(negedge clk);
        check_eq("bp_release_valid", 32'(done_valid), 32'd0);
        check_eq("bp_release_ready", 32'(start_ready), 32'd1);
        check_eq("bp_release_busy", 32'(busy), 32'd0);
        check_eq("bp_ignored_cmd", result, 32'h7FFF_FFFF);

        // Reset asserted for the edge that ends bit 10 of an add.
        a           = 32'hFFFF_FFFF;
        b           = 32'h0000_0001;
        alu_control = 2'b00;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_start_ready", 32'(start_ready), 32'd1);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_done_valid", 32'(done_valid), 32'd0);
        check_eq("mrst_result", result, 32'h0);
        check_eq("mrst_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            check_eq("mrst_no_done", 32'(done_valid), 32'd0);
        end

        run_op("add_3_4", 32'h0000_0003, 32'h0000_0004, 2'b00, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
